vc_line_buffer: RTL and testbench
=================================

// Module: vc_line_buffer
// PURPOSE
//  Parametrised N-entry victim-cache line store with a single request/response handshake.
//  Sits between the L1 datapath and vc_control. Accepts four ops: insert a victim line, read a slot,
//  swap a slot with an L1 line, and invalidate a slot. Tracks per-slot valid bits, picks the
//  insert slot, and returns evicted/old lines through a registered response port.
// PARAMETERS
//  S_LINE     256  line width in bits (multiple of 32)
//  NUM_LINES  8    number of slots (>=2)
//  IDX_W      $clog2(NUM_LINES)  slot index width (derived)
// PORTS
//  clk         in   1          clock
//  rst         in   1          asynchronous reset, active-low (0 = reset)
//  req_valid   in   1          request present
//  req_ready   out  1          request accepted when valid & ready
//  req_op      in   2          vc_op_e: OP_RD=0, OP_INS=1, OP_SWAP=2, OP_INV=3
//  req_idx     in   IDX_W      target slot for RD/SWAP/INV; ignored for INS
//  req_data    in   S_LINE     line to write for INS/SWAP
//  resp_valid  out  1          response present
//  resp_ready  in   1          response consumed when valid & ready
//  resp_data   out  S_LINE     slot contents before the op
//  resp_idx    out  IDX_W      slot the op acted on
//  resp_hit    out  1          slot valid bit at accept time
//  resp_perr   out  1          parity error on resp_data (0 when VC_PARITY_EN undefined)
//  valid_vec   out  NUM_LINES  per-slot valid bits
//  full        out  1          &valid_vec
// BEHAVIOUR
//  Reset (rst=0, async): valid_vec=0, rr_ptr=0, resp_valid=0, and resp_data/idx/hit/perr=0.
//   The data array is not reset. A response pending at reset is dropped.
//  Handshake: req_ready = !resp_valid | resp_ready. Exactly one response per accepted request.
//   The response is registered 1 cycle after accept. Response fields hold stable while resp_valid & !resp_ready.
//   With resp_ready tied high, requests sustain one per cycle.
//  Response FSM: EMPTY/FULL. EMPTY->FULL on accept. FULL stays FULL on resp fire + accept.
//   FULL->EMPTY on resp fire with no accept.
//  OP_RD:   resp_data=line[idx]; no state change.
//  OP_INS:  slot chosen at accept = lowest-index invalid slot if any, else rr_ptr.
//           rr_ptr advances (NUM_LINES-1 wraps to 0) only when the slot was chosen by rr_ptr.
//           Writes req_data, sets valid. resp_data = old contents (evicted line when resp_hit=1).
//  OP_SWAP: resp_data=old line[idx]; writes req_data; sets valid[idx].
//  OP_INV:  resp_data=line[idx]; clears valid[idx]; data kept.
//  Read-before-write: old contents are captured in the same edge as the array write.
//  valid_vec/full update on the accept edge.
//  Reads of invalid slots return stale data with resp_hit=0; this is not an error.
// CONFIGURATION
//  VC_PARITY_EN defined: one even-parity bit per 32-bit word is stored on every write
//   and checked on every response capture. resp_perr=|mismatch. Data is still returned.
//  VC_PARITY_EN undefined: no parity storage; resp_perr tied 0.
// STRUCTURE
//  vc_pkg: vc_op_e enum, OP_* encodings, WORD_W=32 constant.
//  Sub-module vc_repl_ptr: takes valid_vec, owns rr_ptr, outputs the ins slot and the advance decision.
//  Top level holds the array, valid bits, response register and parity.
// TESTING (NUM_LINES=8, S_LINE=256, resp_ready=1 unless stated)
//  1 Reset, then INS data 1..8 back-to-back -> resp_idx 0..7, resp_hit=0, full=1 after the 8th response.
//  2 INS 'h9 when full -> resp_idx=0, resp_hit=1, resp_data='h1. Next INS 'hA -> resp_idx=1, resp_data='h2.
//  3 SWAP idx3 'hAA -> resp_data='h4, hit=1. Then RD idx3 -> resp_data='hAA.
//  4 INV idx2, then INS 'hBB -> resp_idx=2, resp_hit=0, valid_vec=8'hFF.
//  5 RD idx5 with resp_ready=0 for 3 cycles -> resp_valid held, data stable, req_ready=0.
//    Then rst=0 mid-hold -> resp_valid=0 immediately, valid_vec=0.
//  6 VC_PARITY_EN: flip array bit 0 of slot 6, RD idx6 -> resp_perr=1. Macro off -> resp_perr=0.

Source files
------------

// File: rtl/vc_pkg.sv
// Shared types for the victim-cache line buffer: request opcodes, response FSM states, parity word width.
// Latency: n/a (types only). Backpressure: n/a.
package vc_pkg;

  typedef enum logic [1:0] {
    OP_RD   = 2'd0,
    OP_INS  = 2'd1,
    OP_SWAP = 2'd2,
    OP_INV  = 2'd3
  } vc_op_e;

  typedef enum logic {
    RESP_EMPTY = 1'b0,
    RESP_FULL  = 1'b1
  } resp_state_e;

  localparam int WORD_W = 32;

endpackage

// File: rtl/vc_repl_ptr.sv
// Insert-slot selection: lowest invalid slot, else round-robin pointer, which it owns.
// Latency: ins_idx combinational from valid_vec; rr_ptr updates on the accept edge. Backpressure: none.
module vc_repl_ptr #(
  parameter int NUM_LINES = 8,
  parameter int IDX_W     = $clog2(NUM_LINES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LINES-1:0] valid_vec,
  input  logic                 ins_fire,
  output logic [IDX_W-1:0]     ins_idx,
  output logic                 use_rr
);

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] low_idx;
  logic             any_inv;

  // Scan high to low so the last hit left standing is the lowest invalid slot.
  always_comb begin
    any_inv = 1'b0;
    low_idx = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (!valid_vec[i]) begin
        any_inv = 1'b1;
        low_idx = IDX_W'(i);
      end
    end
  end

  assign use_rr  = !any_inv;
  assign ins_idx = any_inv ? low_idx : rr_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (ins_fire && use_rr) begin
      rr_ptr <= (rr_ptr == IDX_W'(NUM_LINES - 1)) ? '0 : rr_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/vc_line_buffer.sv
// Victim-cache line store with RD/INS/SWAP/INV ops; optional per-word parity under VC_PARITY_EN.
// Latency: response registered 1 cycle after accept, one op per cycle sustained.
// Backpressure: req_ready = !resp_valid | resp_ready; response held stable while stalled.
module vc_line_buffer
  import vc_pkg::*;
#(
  parameter int S_LINE    = 256,
  parameter int NUM_LINES = 8,
  parameter int IDX_W     = $clog2(NUM_LINES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [IDX_W-1:0]     req_idx,
  input  logic [S_LINE-1:0]    req_data,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [S_LINE-1:0]    resp_data,
  output logic [IDX_W-1:0]     resp_idx,
  output logic                 resp_hit,
  output logic                 resp_perr,
  output logic [NUM_LINES-1:0] valid_vec,
  output logic                 full
);

  vc_op_e           op;
  resp_state_e      state, state_nxt;
  logic             accept;
  logic             wr_en;
  logic [IDX_W-1:0] ins_idx;
  logic [IDX_W-1:0] tgt_idx;
  logic             use_rr;
  logic [S_LINE-1:0] mem [NUM_LINES];

  assign op         = vc_op_e'(req_op);
  assign resp_valid = (state == RESP_FULL);
  assign req_ready  = !resp_valid || resp_ready;
  assign accept     = req_valid && req_ready;
  assign tgt_idx    = (op == OP_INS) ? ins_idx : req_idx;
  assign wr_en      = accept && (op == OP_INS || op == OP_SWAP);
  assign full       = &valid_vec;

  vc_repl_ptr #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W)
  ) u_repl_ptr (
    .clk       (clk),
    .rst       (rst),
    .valid_vec (valid_vec),
    .ins_fire  (accept && op == OP_INS),
    .ins_idx   (ins_idx),
    .use_rr    (use_rr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RESP_EMPTY;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RESP_EMPTY: if (accept) state_nxt = RESP_FULL;
      RESP_FULL:  if (resp_ready && !accept) state_nxt = RESP_EMPTY;
      default:    state_nxt = RESP_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_vec <= '0;
    end else if (accept) begin
      if (op == OP_INS || op == OP_SWAP) valid_vec[tgt_idx] <= 1'b1;
      else if (op == OP_INV)             valid_vec[tgt_idx] <= 1'b0;
    end
  end

  // Data array is deliberately unreset; the response register samples it in the write edge.
  always_ff @(posedge clk) begin
    if (wr_en) mem[tgt_idx] <= req_data;
  end

  logic perr_nxt;

`ifdef VC_PARITY_EN
  localparam int NWORDS = S_LINE / WORD_W;
  logic [NWORDS-1:0] par_mem [NUM_LINES];
  logic [NWORDS-1:0] wr_par;
  logic [NWORDS-1:0] rd_mismatch;

  always_comb begin
    wr_par      = '0;
    rd_mismatch = '0;
    for (int w = 0; w < NWORDS; w++) begin
      wr_par[w]      = ^req_data[w*WORD_W +: WORD_W];
      rd_mismatch[w] = (^mem[tgt_idx][w*WORD_W +: WORD_W]) ^ par_mem[tgt_idx][w];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) par_mem[tgt_idx] <= wr_par;
  end

  assign perr_nxt = |rd_mismatch;
`else
  assign perr_nxt = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_data <= '0;
      resp_idx  <= '0;
      resp_hit  <= 1'b0;
      resp_perr <= 1'b0;
    end else if (accept) begin
      resp_data <= mem[tgt_idx];
      resp_idx  <= tgt_idx;
      resp_hit  <= valid_vec[tgt_idx];
      resp_perr <= perr_nxt;
    end
  end

endmodule

// File: tb/tb_vc_line_buffer.sv
// Directed + random checks of vc_line_buffer against a slot-level reference model.
// Latency: n/a (bench). Backpressure: exercised with a held response and a reset during the hold.
module tb_vc_line_buffer;

  localparam int S_LINE = 256;
  localparam int N      = 8;
  localparam int IW     = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [1:0]        req_op = 2'd0;
  logic [IW-1:0]     req_idx = '0;
  logic [S_LINE-1:0] req_data = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic [S_LINE-1:0] resp_data;
  logic [IW-1:0]     resp_idx;
  logic              resp_hit;
  logic              resp_perr;
  logic [N-1:0]      valid_vec;
  logic              full;

  vc_line_buffer #(.S_LINE(S_LINE), .NUM_LINES(N), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_idx(req_idx), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_idx(resp_idx), .resp_hit(resp_hit), .resp_perr(resp_perr),
    .valid_vec(valid_vec), .full(full)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: what each slot holds, whether it is live, and the round-robin victim.
  logic [S_LINE-1:0] m_line [N];
  bit                m_known [N];
  bit                m_valid [N];
  int                m_rr;
  bit                m_perr_exp;

  task automatic chk(input string tag, input logic [S_LINE-1:0] obs, input logic [S_LINE-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] m_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_valid[i];
    return v;
  endfunction

  // Issue one request (resp_ready=1) and check its response one edge later.
  task automatic do_req(input int op, input int idx, input logic [S_LINE-1:0] data);
    int          tgt;
    int          first_free;
    logic [S_LINE-1:0] e_data;
    bit          e_known;
    bit          e_hit;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'(op); req_idx = IW'(idx); req_data = data;
    chk("req_ready_idle", S_LINE'(req_ready), S_LINE'(1));
    if (op == 1) begin
      first_free = -1;
      for (int i = N - 1; i >= 0; i--) if (!m_valid[i]) first_free = i;
      if (first_free >= 0) tgt = first_free;
      else begin
        tgt  = m_rr;
        m_rr = (m_rr + 1) % N;
      end
    end else tgt = idx;
    e_data = m_line[tgt]; e_known = m_known[tgt]; e_hit = m_valid[tgt];
    if (op == 1 || op == 2) begin
      m_line[tgt] = data; m_known[tgt] = 1'b1; m_valid[tgt] = 1'b1;
    end else if (op == 3) m_valid[tgt] = 1'b0;
    @(posedge clk); #1;
    chk("resp_valid", S_LINE'(resp_valid), S_LINE'(1));
    chk("resp_idx",   S_LINE'(resp_idx),   S_LINE'(tgt));
    chk("resp_hit",   S_LINE'(resp_hit),   S_LINE'(e_hit));
    if (e_known) begin
      chk("resp_data", resp_data, e_data);
      chk("resp_perr", S_LINE'(resp_perr), S_LINE'(m_perr_exp));
    end
    chk("valid_vec", S_LINE'(valid_vec), S_LINE'(m_vec()));
    chk("full",      S_LINE'(full),      S_LINE'(&m_vec()));
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("resp_drain", S_LINE'(resp_valid), S_LINE'(0));
  endtask

  logic [S_LINE-1:0] held;

  initial begin
    for (int i = 0; i < N; i++) begin
      m_line[i] = '0; m_known[i] = 1'b0; m_valid[i] = 1'b0;
    end
    m_rr = 0;
    m_perr_exp = 1'b0;

    // Reset state
    #12;
    chk("rst_resp_valid", S_LINE'(resp_valid), S_LINE'(0));
    chk("rst_valid_vec",  S_LINE'(valid_vec),  S_LINE'(0));
    chk("rst_resp_data",  resp_data,           S_LINE'(0));
    chk("rst_resp_fields", S_LINE'({resp_idx, resp_hit, resp_perr}), S_LINE'(0));
    chk("rst_full",       S_LINE'(full),       S_LINE'(0));
    @(negedge clk); rst = 1'b1;

    // Fill all slots back-to-back, then round-robin evictions
    for (int i = 1; i <= 8; i++) do_req(1, 0, S_LINE'(i));
    chk("full_after_fill", S_LINE'(full), S_LINE'(1));
    do_req(1, 0, S_LINE'('h9));
    do_req(1, 0, S_LINE'('hA));
    do_req(2, 3, S_LINE'('hAA));
    do_req(0, 3, S_LINE'(0));
    do_req(3, 2, S_LINE'(0));
    do_req(1, 0, S_LINE'('hBB));
    idle_cycle();

    // Stalled response: held stable, no new accept, then reset mid-hold
    @(negedge clk);
    resp_ready = 1'b0; req_valid = 1'b1; req_op = 2'd0; req_idx = 3'd5;
    @(posedge clk); #1;
    held = resp_data;
    chk("hold_data_first", resp_data, m_line[5]);
    @(negedge clk); req_idx = 3'd0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("hold_valid", S_LINE'(resp_valid), S_LINE'(1));
      chk("hold_data",  resp_data,           held);
      chk("hold_idx",   S_LINE'(resp_idx),   S_LINE'(5));
      chk("hold_ready", S_LINE'(req_ready),  S_LINE'(0));
    end
    @(negedge clk); #2;
    req_valid = 1'b0; rst = 1'b0;
    #1;
    chk("midrst_resp_valid", S_LINE'(resp_valid), S_LINE'(0));
    chk("midrst_valid_vec",  S_LINE'(valid_vec),  S_LINE'(0));
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    m_rr = 0;
    @(negedge clk); rst = 1'b1; resp_ready = 1'b1;

    // Parity check on slot 6
`ifdef VC_PARITY_EN
    dut.mem[6][0] = ~dut.mem[6][0];
    m_line[6][0] = ~m_line[6][0];
    m_perr_exp = 1'b1;
    do_req(0, 6, S_LINE'(0));
    m_perr_exp = 1'b0;
    do_req(2, 6, m_line[6]);
`else
    do_req(0, 6, S_LINE'(0));
`endif

    // Random traffic against the model
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 4) == 0) idle_cycle();
      else do_req(int'($urandom_range(0, 3)), int'($urandom_range(0, N - 1)),
                  {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    end
    idle_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
